bcd_serial_adder_disp: RTL and testbench
========================================

// Module: bcd_serial_adder_disp
// PURPOSE
//  Parametrised multi-digit BCD add/subtract unit with a multiplexed 7-segment driver.
//  Operands are latched on a start pulse and processed one digit per clock, LSD first,
//  through a single decimal-corrected digit adder. The result (plus carry digit) is
//  scanned onto DIGITS+1 common-anode displays. Sits between the keypad/operand
//  registers and the board display pins.
// PARAMETERS
//  DIGITS      4     number of BCD digits per operand (>=1)
//  REFRESH_DIV 1024  clk cycles each display digit stays lit (>=2)
// PORTS
//  clk      in   1         system clock, rising edge
//  rst_n    in   1         asynchronous active-low reset
//  start    in   1         1-cycle request; sampled only when busy==0
//  sub      in   1         0: a+b+cin, 1: a-b (cin ignored)
//  cin      in   1         carry in (add mode only)
//  a        in   4*DIGITS  operand A, digit i at [4i+3:4i]
//  b        in   4*DIGITS  operand B, same packing
//  busy     out  1         operation in progress
//  done     out  1         1-cycle pulse when result/cout/neg/err are updated
//  result   out  4*DIGITS  BCD result (10's complement when neg==1)
//  cout     out  1         decimal carry out of the MSD
//  neg      out  1         sub mode and a<b
//  err      out  1         an input digit was >9; result forced to 0
//  seg      out  7         [0:6]=abcdefg, active-low
//  an       out  DIGITS+1  digit enables, active-low; an[DIGITS] = carry digit
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM->IDLE; busy=0, done=0, result=0, cout=0, neg=0, err=0;
//   scan counter=0, an='1 (all off), seg=7'b1111111.
//  FSM IDLE -> RUN -> FIN -> IDLE.
//   IDLE: on start, latch a, b; latch sub; carry<=sub?1:cin; digit idx<=0; goto RUN.
//   RUN: one digit per cycle: z=a_i+b'_i+carry (5 bits), where b'_i=sub?9-b_i:b_i;
//    if z>9 then {carry,s}=z+6 else {carry,s}=z; s written to result digit idx.
//    Any a_i>9 or b_i>9 sets a sticky err_int. idx==DIGITS-1 -> FIN.
//   FIN: cout<=carry; neg<=sub&~carry; err<=err_int, and if err_int then result<=0,
//    cout<=0, neg<=0; done=1 this cycle; goto IDLE.
//  Latency: start at cycle 0 -> done at cycle DIGITS+1; busy=1 cycles 1..DIGITS+1.
//  start while busy is ignored (no queueing). Back-to-back start the cycle after done
//   is accepted. Published outputs hold their last values during RUN; only FIN updates
//   them. Internal digit accumulation uses a shadow register.
//  Display: free-running counter, period REFRESH_DIV; on wrap, scan pointer advances
//   0..DIGITS then wraps to 0. Exactly one an bit low at a time after the first refresh
//   tick post-reset. Digit k<DIGITS shows result digit k; digit DIGITS shows cout (0/1),
//   or the "-" pattern (7'b1111110) when neg. err=1 -> every position shows "E"
//   (7'b0110000). Non-BCD digit codes show blank (7'b1111111), never X.
//  Display scanning continues unaffected during RUN and shows the published result.
//  Reset mid-operation aborts the operation; no done pulse is generated.
// STRUCTURE
//  Package bcd_pkg: SEG_0..SEG_9, SEG_BLANK, SEG_MINUS, SEG_E constants (abcdefg,
//   active-low); FSM state enum {IDLE,RUN,FIN}; function bcd_digit_add(a,b,c)->{c,s}.
//  Sub-module bcd_to_seg: combinational 4-bit code -> 7-bit pattern via package constants.
//  Top module holds the FSM, operand/shadow registers, and scan counter/mux.
// TESTING
//  1. DIGITS=4, a=0x1234, b=0x5678, cin=0, sub=0 -> done at cycle 5; result=0x6912,
//     cout=0.
//  2. a=0x9999, b=0x0001, cin=0 -> result=0x0000, cout=1; carry display shows SEG_1.
//  3. sub=1, a=0x0100, b=0x0250 -> result=0x9850, neg=1, cout=0; carry digit shows "-".
//  4. a=0x12A4 -> err=1, result=0, all digits show SEG_E; next valid op clears err.
//  5. start pulsed at cycles 0 and 2 -> only one done (cycle 5); 2nd start ignored.
//     rst_n low at cycle 3 -> outputs at reset values, no done.
//  6. REFRESH_DIV=4: an sequence 11110,11101,11011,10111,01111, repeating every
//     4 cycles per step; exactly one low bit at a time.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and the decimal-corrected digit adder
// used by the serial BCD add/subtract unit and its display driver.
package bcd_pkg;

  // Segment patterns, bit order abcdefg (index 0 = a), active-low.
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_MINUS = 7'b1111110;
  localparam logic [0:6] SEG_E     = 7'b0110000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Returns {carry, sum}; binary sums above 9 are pushed past 16 by adding 6.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       c);
    logic [5:0] z;
    z = {2'b00, a} + {2'b00, b} + {5'b00000, c};
    if (z > 6'd9) begin
      z = z + 6'd6;
      return {1'b1, z[3:0]};
    end
    return {1'b0, z[3:0]};
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD code to active-low abcdefg pattern; non-BCD codes blank.
module bcd_to_seg
  import bcd_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [0:6] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_serial_adder_disp.sv
// Serial (one digit per clock, LSD first) BCD add/subtract with published
// result registers and a multiplexed common-anode 7-segment scanner.
module bcd_serial_adder_disp
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  neg,
  output logic                  err,
  output logic [0:6]            seg,
  output logic [DIGITS:0]       an,
  output state_e                dbg_state
);

  localparam int W  = 4 * DIGITS;
  localparam int AW = DIGITS + 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(DIGITS + 1);
  localparam int DW = $clog2(REFRESH_DIV);

  // Handshake: start is sampled only while busy is low; done is a one-cycle
  // pulse in the cycle the published result/cout/neg/err first hold new values.

  state_e        state_q;
  logic [W-1:0]  a_q, b_q, acc_q, result_q;
  logic [IW-1:0] idx_q;
  logic          sub_q, carry_q, err_int_q;
  logic          busy_q, done_q, cout_q, neg_q, err_q;

  logic [3:0]    a_dig, b_dig, b_eff;
  logic [4:0]    dsum;
  logic          err_d, last_dig;
  logic [W-1:0]  acc_d;

  always_comb begin
    a_dig    = 4'(a_q >> {idx_q, 2'b00});
    b_dig    = 4'(b_q >> {idx_q, 2'b00});
    b_eff    = sub_q ? (4'd9 - b_dig) : b_dig;
    dsum     = bcd_digit_add(a_dig, b_eff, carry_q);
    err_d    = err_int_q | (a_dig > 4'd9) | (b_dig > 4'd9);
    last_dig = (idx_q == IW'(DIGITS - 1));
    acc_d    = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) acc_d[4*i +: 4] = dsum[3:0];
    end
  end

  // The last RUN cycle publishes, so FIN is the cycle in which done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      idx_q     <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      err_int_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cout_q    <= 1'b0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            sub_q     <= sub;
            carry_q   <= sub | cin;
            idx_q     <= '0;
            acc_q     <= '0;
            err_int_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q     <= acc_d;
          carry_q   <= dsum[4];
          err_int_q <= err_d;
          idx_q     <= idx_q + IW'(1);
          if (last_dig) begin
            state_q  <= FIN;
            done_q   <= 1'b1;
            result_q <= err_d ? '0 : acc_d;
            cout_q   <= ~err_d & dsum[4];
            neg_q    <= ~err_d & sub_q & ~dsum[4];
            err_q    <= err_d;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [DW-1:0] div_q;
  logic [PW-1:0] ptr_q;
  logic          lit_q, tick;

  assign tick = (div_q == DW'(REFRESH_DIV - 1));

  // The first tick only lights position 0; later ticks advance the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      ptr_q <= '0;
      lit_q <= 1'b0;
    end else if (tick) begin
      div_q <= '0;
      if (!lit_q) lit_q <= 1'b1;
      else        ptr_q <= (ptr_q == PW'(DIGITS)) ? '0 : ptr_q + PW'(1);
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  logic [3:0] disp_code;
  logic [0:6] dec_seg;

  always_comb begin
    disp_code = 4'(result_q >> {ptr_q, 2'b00});
    if (ptr_q == PW'(DIGITS)) disp_code = {3'b000, cout_q};
  end

  bcd_to_seg u_bcd_to_seg (
    .code_i (disp_code),
    .seg_o  (dec_seg)
  );

  always_comb begin
    seg = SEG_BLANK;
    an  = '1;
    if (lit_q) begin
      an = ~(AW'(1) << ptr_q);
      if (err_q)                                seg = SEG_E;
      else if (ptr_q == PW'(DIGITS) && neg_q)   seg = SEG_MINUS;
      else                                      seg = dec_seg;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign neg       = neg_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_serial_adder_disp.sv
// Directed bench for the serial BCD adder: arithmetic, latency, error,
// start-while-busy, mid-operation reset and display scan order.
module tb_bcd_serial_adder_disp;
  import bcd_pkg::*;

  localparam int DIGITS = 4;
  localparam int RDIV   = 4;

  localparam logic [6:0] T_SEG0  = 7'b0000001;
  localparam logic [6:0] T_SEG1  = 7'b1001111;
  localparam logic [6:0] T_SEG2  = 7'b0010010;
  localparam logic [6:0] T_SEG6  = 7'b0100000;
  localparam logic [6:0] T_SEG9  = 7'b0000100;
  localparam logic [6:0] T_MINUS = 7'b1111110;
  localparam logic [6:0] T_E     = 7'b0110000;
  localparam logic [6:0] T_BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n, start, sub, cin;
  logic [15:0] a, b, result;
  logic        busy, done, cout, neg, err;
  logic [0:6]  seg;
  logic [4:0]  an;
  state_e      dbg_state;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  bcd_serial_adder_disp #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .cout(cout), .neg(neg), .err(err), .seg(seg), .an(an),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start an op at the next negedge, wait for done and score the outcome.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic tc, input logic [15:0] er,
                        input logic ec, input logic en, input logic ee);
    int lat;
    logic [15:0] e;
    exp_q.push_back(er);
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, DIGITS + 1);
    e = exp_q.pop_front();
    chk({tag, "_res"}, result, e);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_neg"}, neg, en);
    chk({tag, "_err"}, err, ee);
  endtask

  task automatic check_pos(input string tag, input int k, input logic [6:0] exp_seg);
    logic [4:0] want;
    int n;
    want = 5'b11111 ^ (5'b00001 << k);
    n = 0;
    while (an !== want && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_an"}, an, want);
    chk({tag, "_seg"}, seg, exp_seg);
  endtask

  initial begin
    logic [4:0] pat[5];
    int ndone, dcyc, n;
    logic [15:0] e;
    pat[0] = 5'b11110; pat[1] = 5'b11101; pat[2] = 5'b11011;
    pat[3] = 5'b10111; pat[4] = 5'b01111;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_flags", {cout, neg, err}, 0);
    chk("rst_an", an, 5'b11111);
    chk("rst_seg", seg, T_BLANK);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;

    run_op("add1", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
    check_pos("add1_d0", 0, T_SEG2);
    check_pos("add1_d3", 3, T_SEG6);
    check_pos("add1_c", 4, T_SEG0);

    run_op("ovf", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_pos("ovf_c", 4, T_SEG1);
    check_pos("ovf_d0", 0, T_SEG0);

    run_op("cin", 16'h0099, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op("sub_pos", 16'h0250, 16'h0100, 1'b1, 1'b1, 16'h0150, 1'b1, 1'b0, 1'b0);
    run_op("sub_neg", 16'h0100, 16'h0250, 1'b1, 1'b0, 16'h9850, 1'b0, 1'b1, 1'b0);
    check_pos("sub_c", 4, T_MINUS);
    check_pos("sub_d3", 3, T_SEG9);

    run_op("err", 16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= DIGITS; k++) check_pos($sformatf("err_d%0d", k), k, T_E);
    run_op("clr", 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);

    // start again two cycles into the op must be ignored
    exp_q.push_back(16'h6912);
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; dcyc = -1;
    for (int c = 3; c <= 12; c++) begin
      if (c > 3) @(negedge clk);
      if (done) begin
        ndone++;
        dcyc = c;
        e = exp_q.pop_front();
        chk("busy2_res", result, e);
      end
    end
    chk("busy2_ndone", ndone, 1);
    chk("busy2_cyc", dcyc, DIGITS + 1);

    // reset asserted in cycle 3 of an op
    @(negedge clk);
    a = 16'h9999; b = 16'h0001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_res", result, 0);
    chk("mrst_flags", {cout, neg, err}, 0);
    chk("mrst_an", an, 5'b11111);
    chk("mrst_seg", seg, T_BLANK);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;

    ndone = 0;
    n = 0;
    while (an === 5'b11111 && n < 20) begin
      @(negedge clk);
      n++;
      if (done) ndone++;
    end
    for (int s = 0; s < 10; s++) begin
      for (int j = 0; j < RDIV; j++) begin
        if (s != 0 || j != 0) @(negedge clk);
        if (done) ndone++;
        chk($sformatf("scan_s%0d_j%0d", s, j), an, pat[s % 5]);
      end
    end
    chk("mrst_ndone", ndone, 0);
    chk("mrst_state", dbg_state, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
